// File: rtl/vscale_regfile_mp.sv
// Multi-port integer register file: NREAD combinational reads, two writeback ports,
// optional bypass and hardwired x0, per-register busy scoreboard, post-reset clear sweep.
module vscale_regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    init_done,
  input  logic [NREAD*$clog2(NREGS)-1:0] ra,
  output logic [NREAD*XLEN-1:0]   rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    wen0,
  input  logic [$clog2(NREGS)-1:0] wa0,
  input  logic [XLEN-1:0]         wd0,
  input  logic                    wen1,
  input  logic [$clog2(NREGS)-1:0] wa1,
  input  logic [XLEN-1:0]         wd1,
  input  logic                    sb_set,
  input  logic [$clog2(NREGS)-1:0] sb_addr
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nx;
  logic [AW-1:0]   r_ptr, w_ptr_nx;
  logic            r_init_done;
  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_busy, w_busy_nx;
  logic            w_run, w_we0, w_we1, w_sb;

  // Address is a real register that may be written / scoreboarded.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_run     = (r_state == S_RUN);
  assign w_we0     = wen0 & w_run & addr_ok(wa0);
  assign w_we1     = wen1 & w_run & addr_ok(wa1);
  assign w_sb      = sb_set & w_run & addr_ok(sb_addr);
  assign init_done = r_init_done;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    if (r_state == S_INIT) begin
      w_ptr_nx = r_ptr + AW'(1);
      if (r_ptr == LAST_PTR) begin
        w_state_nx = S_RUN;
        w_ptr_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_init_done <= (w_state_nx == S_RUN);
    end
  end

  // Storage has no reset; the sweep clears it, WB1 lands last so it wins a same-address tie.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= '0;
    end else begin
      if (w_we0) r_mem[wa0] <= wd0;
      if (w_we1) r_mem[wa1] <= wd1;
    end
  end

  // Writeback clears busy, a same-cycle issue to that register re-marks it.
  always_comb begin
    w_busy_nx = r_busy;
    if (w_we0) w_busy_nx[wa0] = 1'b0;
    if (w_we1) w_busy_nx[wa1] = 1'b0;
    if (w_sb)  w_busy_nx[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nx;
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] w_ra_i;
      logic          w_hit0, w_hit1;
      w_ra_i = ra[i*AW +: AW];
      w_hit1 = (BYPASS != 0) && w_we1 && (wa1 == w_ra_i);
      w_hit0 = (BYPASS != 0) && w_we0 && (wa0 == w_ra_i);
      if (w_run && addr_ok(w_ra_i)) begin
        if (w_hit1)      rd[i*XLEN +: XLEN] = wd1;
        else if (w_hit0) rd[i*XLEN +: XLEN] = wd0;
        else             rd[i*XLEN +: XLEN] = r_mem[w_ra_i];
        rbusy[i] = r_busy[w_ra_i] & ~(w_hit0 | w_hit1);
      end
    end
  end

endmodule

// File: tb/tb_vscale_regfile_mp.sv
// Bench for vscale_regfile_mp: two configurations (32x2 ports with x0+bypass, 24x4 plain)
// driven side by side and compared against an array-based reference model.
module tb_vscale_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [4:0]  ra [2][4];
  logic        wen0 [2], wen1 [2], sb_set [2];
  logic [4:0]  wa0 [2], wa1 [2], sb_addr [2];
  logic [31:0] wd0 [2], wd1 [2];

  wire [9:0]  ra_a = {ra[0][1], ra[0][0]};
  wire [19:0] ra_b = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};
  logic [63:0]  rd_a;
  logic [127:0] rd_b;
  logic [1:0]   rbusy_a;
  logic [3:0]   rbusy_b;
  logic         done_a, done_b;

  vscale_regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .init_done(done_a), .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .wen0(wen0[0]), .wa0(wa0[0]), .wd0(wd0[0]), .wen1(wen1[0]), .wa1(wa1[0]), .wd1(wd1[0]),
    .sb_set(sb_set[0]), .sb_addr(sb_addr[0]));

  vscale_regfile_mp #(.XLEN(32), .NREGS(24), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .init_done(done_b), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .wen0(wen0[1]), .wa0(wa0[1]), .wd0(wd0[1]), .wen1(wen1[1]), .wa1(wa1[1]), .wd1(wd1[1]),
    .sb_set(sb_set[1]), .sb_addr(sb_addr[1]));

  // Reference model: architectural contents, busy flags, cycles since reset release.
  logic [31:0] m_mem [2][64];
  bit          m_busy [2][64];
  int          m_cnt [2];
  int          checks = 0;
  int          failures = 0;

  function automatic int nr(int k);  return (k == 0) ? 32 : 24; endfunction
  function automatic int np(int k);  return (k == 0) ? 2 : 4;   endfunction
  function automatic bit zr(int k);  return k == 0;             endfunction
  function automatic bit bp(int k);  return k == 0;             endfunction
  function automatic bit run(int k); return m_cnt[k] >= nr(k);  endfunction
  function automatic bit ok(int k, int a); return (a < nr(k)) && !(zr(k) && a == 0); endfunction

  function automatic bit eff(int k, int p);
    if (p == 0) return run(k) && wen0[k] && ok(k, int'(wa0[k]));
    return run(k) && wen1[k] && ok(k, int'(wa1[k]));
  endfunction

  function automatic logic [31:0] exp_rd(int k, int a);
    if (!run(k) || !ok(k, a)) return 32'h0;
    if (bp(k) && eff(k, 1) && int'(wa1[k]) == a) return wd1[k];
    if (bp(k) && eff(k, 0) && int'(wa0[k]) == a) return wd0[k];
    return m_mem[k][a];
  endfunction

  function automatic logic exp_bz(int k, int a);
    if (!run(k) || !ok(k, a)) return 1'b0;
    if (bp(k) && ((eff(k, 1) && int'(wa1[k]) == a) || (eff(k, 0) && int'(wa0[k]) == a))) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_done dut%0d", k), 32'((k == 0) ? done_a : done_b), 32'(run(k)));
      for (int i = 0; i < np(k); i++) begin
        int a;
        a = int'(ra[k][i]);
        chk($sformatf("rd dut%0d port%0d addr%0d", k, i, a),
            (k == 0) ? rd_a[i*32 +: 32] : rd_b[i*32 +: 32], exp_rd(k, a));
        chk($sformatf("rbusy dut%0d port%0d addr%0d", k, i, a),
            32'((k == 0) ? rbusy_a[i] : rbusy_b[i]), 32'(exp_bz(k, a)));
      end
    end
  endtask

  task automatic model_edge(int k);
    bit e0, e1, s;
    e0 = eff(k, 0);
    e1 = eff(k, 1);
    s  = run(k) && sb_set[k] && ok(k, int'(sb_addr[k]));
    if (!run(k)) begin
      m_cnt[k]++;
    end else begin
      if (e0) m_mem[k][wa0[k]] = wd0[k];
      if (e1) m_mem[k][wa1[k]] = wd1[k];
      if (e0) m_busy[k][wa0[k]] = 1'b0;
      if (e1) m_busy[k][wa1[k]] = 1'b0;
      if (s)  m_busy[k][sb_addr[k]] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b0; wen1[k] = 1'b0; sb_set[k] = 1'b0;
      wa0[k] = '0; wa1[k] = '0; sb_addr[k] = '0;
      wd0[k] = '0; wd1[k] = '0;
    end
  endtask

  task automatic set_ra(int k, int a0, int a1, int a2, int a3);
    ra[k][0] = 5'(a0); ra[k][1] = 5'(a1); ra[k][2] = 5'(a2); ra[k][3] = 5'(a3);
  endtask

  // Async reset: busy and init_done must drop before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int r = 0; r < 64; r++) begin
        m_mem[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
    end
    chk("reset rbusy dut0", 32'(rbusy_a), 32'h0);
    chk("reset rbusy dut1", 32'(rbusy_b), 32'h0);
    chk("reset init_done dut0", 32'(done_a), 32'h0);
    chk("reset init_done dut1", 32'(done_b), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n, nb;
    idle();
    set_ra(0, 5, 5, 0, 0);
    set_ra(1, 5, 5, 5, 5);
    do_reset();

    // Sweep: writes and issues during INIT are discarded, r5 reads 0 throughout.
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd5; wd0[k] = 32'hA5A5_0005;
      sb_set[k] = 1'b1; sb_addr[k] = 5'd5;
    end
    repeat (20) step();
    idle();
    repeat (16) step();

    // Same-cycle write and read of r3.
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd3; wd0[k] = 32'hDEAD_BEEF;
      set_ra(k, 3, 3, 3, 3);
    end
    step();
    idle();
    step();

    // WB1 beats WB0 at the same address; x0 handling.
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd7; wd0[k] = 32'h11;
      wen1[k] = 1'b1; wa1[k] = 5'd7; wd1[k] = 32'h22;
      set_ra(k, 7, 0, 7, 7);
    end
    step();
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd0; wd0[k] = 32'h55;
      sb_set[k] = 1'b1; sb_addr[k] = 5'd0;
      set_ra(k, 0, 0, 0, 0);
    end
    step();
    idle();
    step();

    // Scoreboard: set, set+clear (set wins), clear alone.
    for (int k = 0; k < 2; k++) begin
      sb_set[k] = 1'b1; sb_addr[k] = 5'd9;
      set_ra(k, 9, 9, 9, 9);
    end
    step();
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      wen1[k] = 1'b1; wa1[k] = 5'd9; wd1[k] = 32'h99;
      sb_set[k] = 1'b1; sb_addr[k] = 5'd9;
    end
    step();
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd9; wd0[k] = 32'h999;
    end
    step();
    idle();
    step();

    // Out-of-range address on the 24-entry file, then four distinct reads.
    wen0[1] = 1'b1; wa0[1] = 5'd30; wd0[1] = 32'h1234;
    wen1[1] = 1'b1; wa1[1] = 5'd30; wd1[1] = 32'h5678;
    sb_set[1] = 1'b1; sb_addr[1] = 5'd30;
    set_ra(1, 30, 30, 23, 24);
    set_ra(0, 30, 31, 0, 0);
    step();
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      wen0[k] = 1'b1; wa0[k] = 5'd1; wd0[k] = 32'h0101;
      wen1[k] = 1'b1; wa1[k] = 5'd2; wd1[k] = 32'h0202;
    end
    step();
    for (int k = 0; k < 2; k++) begin
      wa0[k] = 5'd3; wd0[k] = 32'h0303;
      wa1[k] = 5'd23; wd1[k] = 32'h2323;
    end
    step();
    idle();
    set_ra(1, 23, 3, 2, 1);
    set_ra(0, 2, 1, 0, 0);
    step();

    // Random traffic with address collisions.
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        wen0[k] = 1'($urandom_range(0, 1));
        wen1[k] = 1'($urandom_range(0, 1));
        sb_set[k] = 1'($urandom_range(0, 1));
        wa0[k] = 5'($urandom_range(0, 31));
        wa1[k] = ($urandom_range(0, 3) == 0) ? wa0[k] : 5'($urandom_range(0, 31));
        sb_addr[k] = ($urandom_range(0, 2) == 0) ? wa0[k] : 5'($urandom_range(0, 31));
        wd0[k] = $urandom();
        wd1[k] = $urandom();
        for (int i = 0; i < 4; i++)
          ra[k][i] = ($urandom_range(0, 2) == 0) ? wa0[k] : 5'($urandom_range(0, 31));
      end
      step();
    end

    // Busy bits set, then async reset; reset again mid-sweep and time the full sweep.
    idle();
    for (int k = 0; k < 2; k++) begin
      sb_set[k] = 1'b1; sb_addr[k] = 5'd12;
      set_ra(k, 12, 13, 12, 13);
    end
    step();
    for (int k = 0; k < 2; k++) sb_addr[k] = 5'd13;
    step();
    idle();
    step();
    do_reset();
    repeat (10) step();
    do_reset();
    n  = 0;
    nb = -1;
    while (!done_a && n < 100) begin
      step();
      n++;
      if (done_b && nb < 0) nb = n;
    end
    chk("sweep length dut0", 32'(n), 32'd32);
    chk("sweep length dut1", 32'(nb), 32'd24);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
